rf_multiport_sb: RTL and testbench

//  Parametrised multi-read-port register file for the pipelined RISC-V core.

---
 rtl/rf_multiport_sb_if.sv | 34 +++
 rtl/rf_multiport_sb.sv | 109 ++++++++++
 tb/tb_rf_multiport_sb.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_multiport_sb_if.sv
// rf_multiport_sb_if
//   Bundles the register-file traffic between the pipeline and rf_multiport_sb.
//   Ports carried (all from the pipeline's point of view):
//     we, waddr, wdata        WB-stage write
//     raddr / rdata / rbusy   packed ID-stage operand reads and busy bits
//     issue, issue_addr       ID-stage scoreboard set
//     dbg_addr / dbg_data     registered debug tap
//   master = pipeline side, slave = register file.
interface rf_multiport_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     issue;
  logic [ADDR_W-1:0]        issue_addr;
  logic [ADDR_W-1:0]        dbg_addr;
  logic [DATA_W-1:0]        dbg_data;

  modport master (
    output we, waddr, wdata, raddr, issue, issue_addr, dbg_addr,
    input  rdata, rbusy, dbg_data
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue, issue_addr, dbg_addr,
    output rdata, rbusy, dbg_data
  );
endinterface

// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb
//   Multi-read-port register file with write-to-read bypass, a per-register
//   busy scoreboard for hazard detection and a registered debug tap.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-high reset (clears data, busy bits, debug tap)
//     bus   rf_multiport_sb_if.slave: write port, NUM_RD packed read ports with
//           busy flags, scoreboard issue port, debug tap address/data
module rf_multiport_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  rf_multiport_sb_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busyNext;
  logic [DATA_W-1:0]        dbgDataReg;
  logic                     writeKeep;

  // Lookups 0..NUM_RD-1 serve the read ports; lookup NUM_RD serves the debug tap.
  logic [DATA_W-1:0]        lookData [NUM_RD+1];
  logic                     lookBusy [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdataPacked;
  logic [NUM_RD-1:0]        rbusyPacked;

  // Writes to register 0 are dropped when it is hardwired to zero.
  assign writeKeep = bus.we && !((ZERO_REG != 0) && (bus.waddr == '0));

  genvar gi;
  generate
    for (gi = 0; gi <= NUM_RD; gi++) begin : gLookup
      logic [ADDR_W-1:0] addr;
      logic              isZero;
      logic              isBypass;

      if (gi < NUM_RD) begin : gPort
        assign addr         = bus.raddr[gi*ADDR_W +: ADDR_W];
        // A register being written this cycle is already resolved when bypassed.
        assign lookBusy[gi] = busy[addr] & ~isBypass;
      end else begin : gDbg
        assign addr = bus.dbg_addr;
      end

      assign isZero       = (ZERO_REG != 0) && (addr == '0);
      assign isBypass     = (BYPASS != 0) && bus.we && (bus.waddr == addr);
      // Zero-register rule outranks the bypass, so x0 never forwards wdata.
      assign lookData[gi] = isZero   ? '0 :
                            isBypass ? bus.wdata : mem[addr];
    end
  endgenerate

  always_comb begin
    rdataPacked = '0;
    rbusyPacked = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rdataPacked[k*DATA_W +: DATA_W] = lookData[k];
      rbusyPacked[k]                  = lookBusy[k];
    end
  end

  assign bus.rdata    = rdataPacked;
  assign bus.rbusy    = rbusyPacked;
  assign bus.dbg_data = dbgDataReg;

  // Clear for the retiring writer first, then set for the issuing one, so a
  // same-address collision leaves the register busy for the newer writer.
  always_comb begin
    busyNext = busy;
    if (bus.we) begin
      busyNext[bus.waddr] = 1'b0;
    end
    if (bus.issue) begin
      busyNext[bus.issue_addr] = 1'b1;
    end
    if (ZERO_REG != 0) begin
      busyNext[0] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (writeKeep) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= '0;
      dbgDataReg <= '0;
    end else begin
      busy       <= busyNext;
      dbgDataReg <= lookData[NUM_RD];
    end
  end

endmodule

// File: tb/tb_rf_multiport_sb.sv
// tb_rf_multiport_sb
//   Drives three register-file builds from one shared random/directed stimulus:
//     inst0: DATA_W=32 ADDR_W=5 NUM_RD=2 ZERO_REG=1 BYPASS=1
//     inst1: DATA_W=64 ADDR_W=4 NUM_RD=3 ZERO_REG=1 BYPASS=1
//     inst2: DATA_W=32 ADDR_W=5 NUM_RD=2 ZERO_REG=0 BYPASS=0
//   A behavioural array model predicts every output; a compare process checks
//   all three builds each cycle, and directed steps pin literal values.
module tb_rf_multiport_sb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Shared stimulus, sized for the widest build; narrower builds take low bits.
  logic        stWe;
  logic [4:0]  stWaddr;
  logic [63:0] stWdata;
  logic [4:0]  stRaddr [3];
  logic        stIssue;
  logic [4:0]  stIssueAddr;
  logic [4:0]  stDbgAddr;

  int cfgDw  [3] = '{32, 64, 32};
  int cfgAw  [3] = '{5, 4, 5};
  int cfgNrd [3] = '{2, 3, 2};
  int cfgZr  [3] = '{1, 1, 0};
  int cfgBp  [3] = '{1, 1, 0};

  int vectors     = 0;
  int miscompares = 0;
  logic checkEn   = 1'b0;

  rf_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if0 ();
  rf_multiport_sb_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3)) if1 ();
  rf_multiport_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) if2 ();

  rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  rf_multiport_sb #(.DATA_W(64), .ADDR_W(4), .NUM_RD(3), .ZERO_REG(1), .BYPASS(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));
  rf_multiport_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0))
    dut2 (.clk(clk), .rst(rst), .bus(if2));

  assign if0.we = stWe;  assign if1.we = stWe;  assign if2.we = stWe;
  assign if0.issue = stIssue;  assign if1.issue = stIssue;  assign if2.issue = stIssue;
  assign if0.waddr = stWaddr;  assign if1.waddr = stWaddr[3:0];  assign if2.waddr = stWaddr;
  assign if0.wdata = stWdata[31:0];  assign if1.wdata = stWdata;  assign if2.wdata = stWdata[31:0];
  assign if0.issue_addr = stIssueAddr;
  assign if1.issue_addr = stIssueAddr[3:0];
  assign if2.issue_addr = stIssueAddr;
  assign if0.dbg_addr = stDbgAddr;
  assign if1.dbg_addr = stDbgAddr[3:0];
  assign if2.dbg_addr = stDbgAddr;
  assign if0.raddr = {stRaddr[1], stRaddr[0]};
  assign if1.raddr = {stRaddr[2][3:0], stRaddr[1][3:0], stRaddr[0][3:0]};
  assign if2.raddr = {stRaddr[1], stRaddr[0]};

  // Outputs gathered into uniform 64-bit views.
  logic [63:0] outData [3][3];
  logic        outBusy [3][3];
  logic [63:0] outDbg  [3];

  assign outData[0][0] = {32'h0, if0.rdata[31:0]};
  assign outData[0][1] = {32'h0, if0.rdata[63:32]};
  assign outData[0][2] = 64'h0;
  assign outData[1][0] = if1.rdata[63:0];
  assign outData[1][1] = if1.rdata[127:64];
  assign outData[1][2] = if1.rdata[191:128];
  assign outData[2][0] = {32'h0, if2.rdata[31:0]};
  assign outData[2][1] = {32'h0, if2.rdata[63:32]};
  assign outData[2][2] = 64'h0;
  assign outBusy[0][0] = if0.rbusy[0];
  assign outBusy[0][1] = if0.rbusy[1];
  assign outBusy[0][2] = 1'b0;
  assign outBusy[1][0] = if1.rbusy[0];
  assign outBusy[1][1] = if1.rbusy[1];
  assign outBusy[1][2] = if1.rbusy[2];
  assign outBusy[2][0] = if2.rbusy[0];
  assign outBusy[2][1] = if2.rbusy[1];
  assign outBusy[2][2] = 1'b0;
  assign outDbg[0] = {32'h0, if0.dbg_data};
  assign outDbg[1] = if1.dbg_data;
  assign outDbg[2] = {32'h0, if2.dbg_data};

  // ---------------- behavioural model ----------------
  logic [63:0] modelMem  [3][32];
  logic [31:0] modelBusy [3];
  logic [63:0] modelDbg  [3];

  function automatic logic [4:0] amask(int i);
    return 5'((32'd1 << cfgAw[i]) - 32'd1);
  endfunction

  function automatic logic [63:0] dmask(int i);
    return (cfgDw[i] == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction

  function automatic logic bypassHit(int i, logic [4:0] a);
    return (cfgBp[i] == 1) && stWe && ((stWaddr & amask(i)) == (a & amask(i)));
  endfunction

  function automatic logic [63:0] expData(int i, logic [4:0] a);
    logic [4:0] am;
    am = a & amask(i);
    if (cfgZr[i] == 1 && am == 5'd0) return 64'h0;
    if (bypassHit(i, a)) return stWdata & dmask(i);
    return modelMem[i][am];
  endfunction

  function automatic logic expBusy(int i, logic [4:0] a);
    return modelBusy[i][a & amask(i)] && !bypassHit(i, a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        for (int r = 0; r < 32; r++) modelMem[i][r] <= 64'h0;
        modelBusy[i] <= 32'h0;
        modelDbg[i]  <= 64'h0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        modelDbg[i] <= expData(i, stDbgAddr);
        if (stWe && !(cfgZr[i] == 1 && (stWaddr & amask(i)) == 5'd0))
          modelMem[i][stWaddr & amask(i)] <= stWdata & dmask(i);
        // Later assignments win: clear, then set, then hold x0 idle.
        if (stWe)          modelBusy[i][stWaddr & amask(i)] <= 1'b0;
        if (stIssue)       modelBusy[i][stIssueAddr & amask(i)] <= 1'b1;
        if (cfgZr[i] == 1) modelBusy[i][0] <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < cfgNrd[i]; k++) begin
          chk($sformatf("inst%0d port%0d rdata", i, k), outData[i][k], expData(i, stRaddr[k]));
          chk($sformatf("inst%0d port%0d rbusy", i, k), {63'h0, outBusy[i][k]},
              {63'h0, expBusy(i, stRaddr[k])});
        end
        chk($sformatf("inst%0d dbg_data", i), outDbg[i], modelDbg[i]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stWe = 1'b0;
    stIssue = 1'b0;
  endtask

  initial begin
    stWe = 1'b0; stWaddr = '0; stWdata = '0;
    stIssue = 1'b0; stIssueAddr = '0; stDbgAddr = '0;
    for (int k = 0; k < 3; k++) stRaddr[k] = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checkEn = 1'b1;

    // Reset state.
    stRaddr[0] = 5'd5;
    #1;
    chk("reset rdata0", outData[0][0], 64'h0);
    chk("reset rbusy0", {63'h0, outBusy[0][0]}, 64'h0);
    chk("reset dbg", outDbg[0], 64'h0);

    // T1: preload x5 and mark busy, then async reset mid-cycle.
    tick();
    stWe = 1'b1; stWaddr = 5'd5; stWdata = 64'hDEADBEEF;
    stIssue = 1'b1; stIssueAddr = 5'd5;
    tick();
    idle(); stRaddr[0] = 5'd5; stDbgAddr = 5'd5;
    tick();
    chk("t1 preload rdata", outData[0][0], 64'hDEADBEEF);
    chk("t1 preload rbusy", {63'h0, outBusy[0][0]}, 64'h1);
    chk("t1 preload dbg", outDbg[0], 64'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    chk("t1 async rdata", outData[0][0], 64'h0);
    chk("t1 async rbusy", {63'h0, outBusy[0][0]}, 64'h0);
    chk("t1 async dbg", outDbg[0], 64'h0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // T2: write then read on both ports.
    stWe = 1'b1; stWaddr = 5'd3; stWdata = 64'h12345678;
    tick();
    idle(); stRaddr[0] = 5'd3; stRaddr[1] = 5'd3;
    #1;
    chk("t2 port0", outData[0][0], 64'h12345678);
    chk("t2 port1", outData[0][1], 64'h12345678);
    tick();

    // T3: zero register ignores writes and issue.
    stWe = 1'b1; stWaddr = 5'd0; stWdata = 64'hFFFFFFFF;
    stIssue = 1'b1; stIssueAddr = 5'd0; stRaddr[0] = 5'd0;
    #1;
    chk("t3 same-cycle rdata", outData[0][0], 64'h0);
    chk("t3 same-cycle rbusy", {63'h0, outBusy[0][0]}, 64'h0);
    tick();
    idle();
    #1;
    chk("t3 later rdata", outData[0][0], 64'h0);
    chk("t3 later rbusy", {63'h0, outBusy[0][0]}, 64'h0);
    tick();

    // T4: bypass forwards new data; the no-bypass build sees the old value.
    stWe = 1'b1; stWaddr = 5'd7; stWdata = 64'h11;
    tick();
    stWdata = 64'h22; stRaddr[1] = 5'd7;
    #1;
    chk("t4 bypass", outData[0][1], 64'h22);
    chk("t4 no bypass", outData[2][1], 64'h11);
    tick();
    idle();

    // T5: scoreboard set, collision, clear.
    stIssue = 1'b1; stIssueAddr = 5'd9;
    tick();
    idle(); stRaddr[0] = 5'd9;
    #1;
    chk("t5 issued", {63'h0, outBusy[0][0]}, 64'h1);
    stWe = 1'b1; stWaddr = 5'd9; stWdata = 64'h99;
    stIssue = 1'b1; stIssueAddr = 5'd9;
    tick();
    stIssue = 1'b0;
    #1;
    chk("t5 set wins", {63'h0, outBusy[2][0]}, 64'h1);
    chk("t5 bypass hides busy", {63'h0, outBusy[0][0]}, 64'h0);
    tick();
    idle();
    #1;
    chk("t5 cleared", {63'h0, outBusy[0][0]}, 64'h0);
    tick();

    // Randomised traffic; small addresses favoured to provoke aliasing.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      stWe        = ($urandom_range(0, 1) == 1);
      stWaddr     = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      stWdata     = {$urandom, $urandom};
      stIssue     = ($urandom_range(0, 4) < 2);
      stIssueAddr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      stDbgAddr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      for (int k = 0; k < 3; k++)
        stRaddr[k] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      tick();
    end

    idle();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
